// File: rtl/issue_sched_pkg.sv
// -----------------------------------------------------------------------------
// issue_sched_pkg
// Shared rename/issue types used by the issue scheduler and its neighbours.
//   p_reg_t     : physical register tag (valid, idx)
//   src_t       : renamed source operand (valid, idx, ready)
//   br_result_t : branch outcome (valid, hit); valid && !hit means flush
//   rinstr_t    : renamed instruction (valid, op, rd, rs1, rs2)
//   iq_entry_t  : issue-queue entry (valid, age rank, instruction)
//   IQ_DEPTH    : default issue-queue depth
// Helper functions implement the tag-broadcast wakeup and the source
// readiness test so every stage applies them identically.
// -----------------------------------------------------------------------------
package issue_sched_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int PREG_W   = 6;
  localparam int OP_W     = 8;
  // Wide enough for the age rank of the largest supported queue (16).
  localparam int IQ_AGE_W = 4;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
    logic              ready;
  } src_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    p_reg_t          rd;
    src_t            rs1;
    src_t            rs2;
  } rinstr_t;

  // age is a rank: the number of older valid entries. Ranks are unique among
  // valid entries, so the oldest entry always has the smallest rank and there
  // is no wrap-around to disambiguate.
  typedef struct packed {
    logic                valid;
    logic [IQ_AGE_W-1:0] age;
    rinstr_t             instr;
  } iq_entry_t;

  // p0 is hard-wired ready, so a broadcast of tag 0 never wakes anything.
  function automatic logic wb_match(src_t s, p_reg_t wb);
    return wb.valid && (wb.idx != '0) && (s.idx == wb.idx);
  endfunction

  function automatic src_t src_wake(src_t s, p_reg_t wb);
    src_t r;
    r = s;
    if (wb_match(s, wb)) r.ready = 1'b1;
    return r;
  endfunction

  // An unused source never blocks issue.
  function automatic logic src_ready(src_t s);
    return !s.valid || s.ready;
  endfunction

endpackage

// File: rtl/issue_sched_if.sv
// -----------------------------------------------------------------------------
// issue_sched_if
// Bundles the scheduler's datapath and handshake signals.
//   br_result_i   : branch outcome; valid && !hit flushes the queue
//   rinstr_i      : renamed instruction from rename (rinstr_i.valid = offer)
//   rinstr_ready_o: scheduler can accept rinstr_i this cycle
//   wb_i          : writeback tag broadcast
//   issue_o       : registered instruction toward the functional unit
//   issue_ready_i : functional unit accepts issue_o
//   count_o       : number of occupied queue entries
// modport master = rename/FU side, modport slave = scheduler.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready in the same cycle, and once
// issue_o.valid is high issue_o holds bit-identical until issue_ready_i.
// -----------------------------------------------------------------------------
interface issue_sched_if
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  br_result_t       br_result_i;
  rinstr_t          rinstr_i;
  logic             rinstr_ready_o;
  p_reg_t           wb_i;
  rinstr_t          issue_o;
  logic             issue_ready_i;
  logic [CNT_W-1:0] count_o;

  modport master (
    output br_result_i,
    output rinstr_i,
    output wb_i,
    output issue_ready_i,
    input  rinstr_ready_o,
    input  issue_o,
    input  count_o
  );

  modport slave (
    input  br_result_i,
    input  rinstr_i,
    input  wb_i,
    input  issue_ready_i,
    output rinstr_ready_o,
    output issue_o,
    output count_o
  );

endinterface

// File: rtl/iq_age_select.sv
// -----------------------------------------------------------------------------
// iq_age_select
// Picks the oldest eligible issue-queue entry.
//   eligible_i : per-entry "valid and all sources ready"
//   age_i      : per-entry age rank (0 = oldest)
//   sel_idx_o  : index of the eligible entry with the smallest rank
//   found_o    : at least one entry is eligible
// Ranks of valid entries are unique, so the result never depends on a tie.
// -----------------------------------------------------------------------------
module iq_age_select
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]               eligible_i,
  input  logic [DEPTH-1:0][IQ_AGE_W-1:0] age_i,
  output logic [IDX_W-1:0]               sel_idx_o,
  output logic                           found_o
);

  logic [IDX_W-1:0]    best_idx;
  logic [IQ_AGE_W-1:0] best_age;
  logic                any;

  always_comb begin
    best_idx = '0;
    best_age = '1;
    any      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible_i[i] && (!any || (age_i[i] < best_age))) begin
        any      = 1'b1;
        best_idx = IDX_W'(i);
        best_age = age_i[i];
      end
    end
  end

  assign sel_idx_o = best_idx;
  assign found_o   = any;

endmodule

// File: rtl/issue_sched.sv
// -----------------------------------------------------------------------------
// issue_sched
// Out-of-order issue queue: holds up to DEPTH renamed instructions, wakes
// their sources on writeback tag broadcasts and issues the oldest ready
// instruction into a single registered issue slot.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears all entries and issue_o)
//   bus    : issue_sched_if.slave (rename input, wakeup, flush, issue output,
//            occupancy count)
// Parameter DEPTH: number of entries, power of two in 2..16.
// Build option IQ_WB_FORWARD_EN: when defined, a tag matching wb_i in the
// current cycle already counts as ready for selection (zero-cycle wakeup);
// otherwise an entry becomes eligible the cycle after its ready bit is set.
// -----------------------------------------------------------------------------
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input logic          clk_i,
  input logic          rst_ni,
  issue_sched_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t [DEPTH-1:0] entry_q;
  rinstr_t               issue_q;
  logic [CNT_W-1:0]      count_q;

  logic                           flush;
  logic                           enq;
  logic                           do_issue;
  logic                           found;
  logic [DEPTH-1:0]               eligible;
  logic [DEPTH-1:0][IQ_AGE_W-1:0] ages;
  logic [IDX_W-1:0]               sel_idx;
  logic [IDX_W-1:0]               free_idx;
  logic [IQ_AGE_W-1:0]            sel_age;
  logic [CNT_W-1:0]               count_after_deq;
  logic [CNT_W-1:0]               count_next;
  iq_entry_t                      enq_entry;
  rinstr_t                        sel_instr;

  assign flush = bus.br_result_i.valid && !bus.br_result_i.hit;

  assign bus.rinstr_ready_o = (count_q < CNT_W'(DEPTH));
  assign enq                = bus.rinstr_i.valid && bus.rinstr_ready_o && !flush;

  // The issue slot is refilled whenever it is empty or being consumed.
  assign do_issue = found && (!issue_q.valid || bus.issue_ready_i);

  always_comb begin
    eligible = '0;
    ages     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ages[i] = entry_q[i].age;
`ifdef IQ_WB_FORWARD_EN
      eligible[i] = entry_q[i].valid
                 && src_ready(src_wake(entry_q[i].instr.rs1, bus.wb_i))
                 && src_ready(src_wake(entry_q[i].instr.rs2, bus.wb_i));
`else
      eligible[i] = entry_q[i].valid
                 && src_ready(entry_q[i].instr.rs1)
                 && src_ready(entry_q[i].instr.rs2);
`endif
    end
  end

  iq_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .eligible_i (eligible),
    .age_i      (ages),
    .sel_idx_o  (sel_idx),
    .found_o    (found)
  );

  // Lowest-numbered free slot. Enqueue is only allowed below DEPTH, so a free
  // slot always exists when enq is high.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // The issued copy also sees this cycle's wakeup so downstream never gets a
  // stale ready bit.
  always_comb begin
    sel_instr     = entry_q[sel_idx].instr;
    sel_instr.rs1 = src_wake(sel_instr.rs1, bus.wb_i);
    sel_instr.rs2 = src_wake(sel_instr.rs2, bus.wb_i);
    sel_age       = entry_q[sel_idx].age;
  end

  // A new entry ranks behind every entry that survives this cycle.
  assign count_after_deq = count_q - CNT_W'(do_issue);
  assign count_next      = count_q + CNT_W'(enq) - CNT_W'(do_issue);

  always_comb begin
    enq_entry             = '0;
    enq_entry.valid       = 1'b1;
    enq_entry.age         = IQ_AGE_W'(count_after_deq);
    enq_entry.instr       = bus.rinstr_i;
    enq_entry.instr.valid = 1'b1;
    enq_entry.instr.rs1   = src_wake(bus.rinstr_i.rs1, bus.wb_i);
    enq_entry.instr.rs2   = src_wake(bus.rinstr_i.rs2, bus.wb_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      issue_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      entry_q <= '0;
      issue_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_q[i].valid) begin
          entry_q[i].instr.rs1 <= src_wake(entry_q[i].instr.rs1, bus.wb_i);
          entry_q[i].instr.rs2 <= src_wake(entry_q[i].instr.rs2, bus.wb_i);
          if (do_issue && (sel_idx == IDX_W'(i))) begin
            entry_q[i].valid <= 1'b0;
          end else if (do_issue && (entry_q[i].age > sel_age)) begin
            // Close the gap left by the departing entry to keep ranks dense.
            entry_q[i].age <= entry_q[i].age - IQ_AGE_W'(1);
          end
        end
      end
      if (enq) entry_q[free_idx] <= enq_entry;
      if (do_issue) begin
        issue_q <= sel_instr;
      end else if (bus.issue_ready_i) begin
        issue_q <= '0;
      end
      count_q <= count_next;
    end
  end

  assign bus.issue_o = issue_q;
  assign bus.count_o = count_q;

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of issue-queue entries (power of two, 2..16).
REQ-002 SHALL have clock and reset: reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  async active-low reset.
REQ-005 SHALL have port br_result_i  input  br_result_t  branch outcome; valid && !hit = flush.
REQ-006 SHALL have port rinstr_i  input  rinstr_t  renamed instruction from rename stage.
REQ-007 SHALL have port rinstr_ready_o  output  1  queue accepts rinstr_i this cycle.
REQ-008 SHALL have port wb_i  input  p_reg_t  writeback tag broadcast (valid, idx).
REQ-009 SHALL have port issue_o  output  rinstr_t  registered instruction to functional unit.
REQ-010 SHALL have port issue_ready_i  input  1  functional unit accepts issue_o.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-012 SHALL enqueue rinstr_i on a rising edge when rinstr_i.valid && rinstr_ready_o && no flush; the entry records rd, rs1, rs2 (valid, idx, ready) and age.
REQ-013 SHALL drive rinstr_ready_o = (count_o < DEPTH); no same-cycle enqueue-while-full bypass.
REQ-014 SHALL treat a source as ready if its ready bit is set or its valid bit is clear.
REQ-015 SHALL, when wb_i.valid, set the ready bit of every stored source whose idx == wb_i.idx, including the source fields of an instruction enqueued in that same cycle.
REQ-016 SHALL ignore wb_i.idx == 0 (p0 is always ready).
REQ-017 SHALL select each cycle the oldest (earliest enqueued) entry with all sources ready.
REQ-018 SHALL load the selected entry into the issue_o register and free it when issue_o is empty (issue_o.valid == 0) or issue_ready_i == 1; otherwise issue_o SHALL remain stable.
REQ-019 SHALL give minimum latency of 1 cycle: an instruction enqueued with all sources ready at edge N appears on issue_o after edge N+1.
REQ-020 SHALL clear issue_o.valid after a handshake when no entry is eligible.
REQ-021 SHALL update count_o as count + enqueue - dequeue; simultaneous enqueue and dequeue leaves count unchanged.
REQ-022 SHALL, on flush (br_result_i.valid && !br_result_i.hit), invalidate all entries and issue_o at the next edge, set count_o to 0 and drop any same-cycle enqueue; flush SHALL have priority over enqueue, wakeup and issue.
REQ-023 SHALL keep the age order correct across any entry reuse (no wrap-around ambiguity).

Reset
REQ-024 SHALL, while rst_ni is low, hold all entries invalid, issue_o = '0, count_o = 0 and rinstr_ready_o = 1.
REQ-025 SHALL, on reset asserted mid-operation, discard all in-flight entries immediately, without draining.

Configuration
REQ-026 SHALL, with IQ_WB_FORWARD_EN defined, treat a same-cycle wb_i tag match as ready for selection (zero-cycle wakeup).
REQ-027 SHALL, without IQ_WB_FORWARD_EN, make an entry eligible only from the cycle after its ready bit is set; the REQ-015 wakeup is unchanged.

Structure
REQ-028 SHALL place iq_entry_t and the default IQ_DEPTH in the shared rename package, alongside rinstr_t, p_reg_t and br_result_t.
REQ-029 SHALL contain one sub-module iq_age_select (per-entry eligible vector + age -> oldest index + found flag).

Verification
REQ-030 SHALL cover: enqueue rs1=p5 ready, rs2 invalid at edge 1 -> issue_o.valid with rs1.idx=5 after edge 2.
REQ-031 SHALL cover: enqueue A (rs1=p40 not ready) then B (ready); wb_i idx=40 two cycles later -> B issues first, then A (one cycle later with forward, two without).
REQ-032 SHALL cover: fill 8 entries with issue_ready_i=0 -> rinstr_ready_o=0, count_o=8; 9th rinstr_i.valid is not accepted; issue_ready_i=1 for one cycle -> count_o=7, rinstr_ready_o=1.
REQ-033 SHALL cover: flush with 5 entries and issue_o valid, plus a same-cycle enqueue -> next cycle count_o=0, issue_o.valid=0, enqueued instruction absent.
REQ-034 SHALL cover: issue_ready_i=0 for 3 cycles while issue_o is valid -> issue_o bit-identical across all 3 cycles.
REQ-035 SHALL cover: wb_i idx=0 valid while an entry waits on p0-not-ready -> no state change.
